boot_run_ctrl: RTL and testbench

- Synthesisable boot-and-run sequencer for the CPU top; replaces fixed testbench reset pulse and fixed cycle-budget stop.
- Copies a boot image from a synchronous ROM into instruction memory, holds the CPU in reset for a programmable count, then releases it.
- Counts run cycles; ends the run on halt detection (PC stable) or on cycle-budget timeout, and reports which.

---
 rtl/boot_run_ctrl_if.sv | 28 ++
 rtl/boot_run_ctrl.sv | 138 +++++++++++++
 tb/tb_boot_run_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/boot_run_ctrl_if.sv
// Boot-copy bus between the sequencer, the boot ROM and instruction memory.
// The master drives the ROM read address and the imem write port.
interface boot_run_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output rom_addr,
        input  rom_data,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/boot_run_ctrl.sv
// Boot-and-run sequencer: copies the boot image ROM->imem, holds the CPU in
// reset, releases it and ends the run on halt (stable PC) or cycle budget.
module boot_run_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int BOOT_WORDS   = 64,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 50,
    parameter int HALT_STABLE  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    boot_run_ctrl_if.master        mem,
    output logic                   cpu_reset,
    input  logic [31:0]            cpu_pc,
    output logic [31:0]            cycle_count,
    output logic [2:0]             state,
    output logic                   done,
    output logic                   halted,
    output logic                   timeout
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        HOLD    = 3'd2,
        RUN     = 3'd3,
        HALTED  = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rom_addr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic [31:0]       load_cnt;
    logic [31:0]       hold_cnt;
    logic [31:0]       prev_pc;
    logic [31:0]       stable;
    logic              first_run;
    logic [31:0]       cnt_next;
    logic [31:0]       stable_next;

    assign state          = state_q;
    assign mem.rom_addr   = rom_addr;
    assign mem.imem_we    = imem_we;
    assign mem.imem_addr  = imem_addr;
    assign mem.imem_wdata = imem_wdata;

    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    always_comb begin
        cnt_next    = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
        stable_next = '0;
        if (!first_run && (cpu_pc == prev_pc))
            stable_next = stable + 32'd1;
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_reset   <= 1'b1;
            rom_addr    <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            load_cnt    <= '0;
            hold_cnt    <= '0;
            prev_pc     <= '0;
            stable      <= '0;
            first_run   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_q)
                IDLE, HALTED, TIMEOUT: begin
                    if (start) begin
                        state_q     <= (BOOT_WORDS == 0) ? HOLD : LOAD;
                        cpu_reset   <= 1'b1;
                        rom_addr    <= '0;
                        load_cnt    <= '0;
                        hold_cnt    <= '0;
                        cycle_count <= '0;
                        done        <= 1'b0;
                        halted      <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                LOAD: begin
                    // rom_data answers the rom_addr registered this cycle; it lands in imem next cycle.
                    if (load_cnt == 32'(BOOT_WORDS)) begin
                        state_q  <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_addr  <= rom_addr;
                        imem_wdata <= mem.rom_data;
                        if (load_cnt != 32'(BOOT_WORDS - 1))
                            rom_addr <= rom_addr + ADDR_W'(1);
                    end
                    load_cnt <= load_cnt + 32'd1;
                end
                HOLD: begin
                    if (hold_cnt == 32'(RESET_CYCLES - 1)) begin
                        state_q   <= RUN;
                        cpu_reset <= 1'b0;
                        first_run <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                RUN: begin
                    cycle_count <= cnt_next;
                    prev_pc     <= cpu_pc;
                    stable      <= stable_next;
                    first_run   <= 1'b0;
                    // Halt detection takes priority over a budget expiring in the same cycle.
                    if (stable_next == 32'(HALT_STABLE)) begin
                        state_q   <= HALTED;
                        cpu_reset <= 1'b1;
                        done      <= 1'b1;
                        halted    <= 1'b1;
                    end else if ((MAX_CYCLES != 0) && (cnt_next == 32'(MAX_CYCLES))) begin
                        state_q   <= TIMEOUT;
                        cpu_reset <= 1'b1;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_run_ctrl.sv
// Directed bench for boot_run_ctrl: image copy, reset hold, halt, timeout,
// halt/timeout collision, restart and reset during load.
module tb_boot_run_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, reset_b, start, start_b;
    logic [31:0] cpu_pc, cpu_pc_b;
    logic        cpu_reset, done, halted, timeout;
    logic [31:0] cycle_count;
    logic [2:0]  state;
    logic        cpu_reset_b, done_b, halted_b, timeout_b;
    logic [31:0] cycle_count_b;
    logic [2:0]  state_b;

    int n_checks = 0;
    int n_pass   = 0;

    boot_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    boot_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

    // Boot ROM contents: word k holds 0xA000_0000 + k, read at the registered address.
    assign bus.rom_data   = 32'hA000_0000 + 32'(bus.rom_addr);
    assign bus_b.rom_data = 32'hDEAD_0000 + 32'(bus_b.rom_addr);

    boot_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOOT_WORDS(64),
        .RESET_CYCLES(1), .MAX_CYCLES(50), .HALT_STABLE(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mem(bus),
        .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .cycle_count(cycle_count),
        .state(state), .done(done), .halted(halted), .timeout(timeout)
    );

    boot_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BOOT_WORDS(0),
        .RESET_CYCLES(3), .MAX_CYCLES(50), .HALT_STABLE(4)
    ) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .mem(bus_b),
        .cpu_reset(cpu_reset_b), .cpu_pc(cpu_pc_b), .cycle_count(cycle_count_b),
        .state(state_b), .done(done_b), .halted(halted_b), .timeout(timeout_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Entered on the first LOAD cycle; returns on the first RUN cycle.
    task automatic load_and_release(input string tag);
        int writes, first_w, last_w, fall, load_cyc;
        writes = 0; first_w = -1; last_w = -1; fall = -1; load_cyc = 0;
        check({tag, "_rom_addr0"}, 32'(bus.rom_addr), 32'd0);
        for (int c = 0; c < 200 && fall < 0; c++) begin
            if (state == 3'd1) load_cyc++;
            if (bus.imem_we) begin
                check({tag, "_waddr"}, 32'(bus.imem_addr), 32'(writes));
                check({tag, "_wdata"}, bus.imem_wdata, 32'hA000_0000 + 32'(writes));
                if (first_w < 0) first_w = c;
                last_w = c;
                writes++;
            end
            if (!cpu_reset) fall = c;
            else tick();
        end
        check({tag, "_released"}, 32'(fall >= 0), 32'd1);
        check({tag, "_n_writes"}, 32'(writes), 32'd64);
        check({tag, "_first_write"}, 32'(first_w), 32'd1);
        check({tag, "_write_span"}, 32'(last_w - first_w), 32'd63);
        check({tag, "_load_cycles"}, 32'(load_cyc), 32'd65);
        check({tag, "_reset_fall"}, 32'(fall - last_w), 32'd2);
        check({tag, "_run_state"}, 32'(state), 32'd3);
        check({tag, "_run_count0"}, cycle_count, 32'd0);
    endtask

    // Drives cpu_pc per RUN cycle: base+4*(i-1) for i<=inc, then hold.
    task automatic run_pc(input int inc, input logic [31:0] base, input logic [31:0] hold,
                          input int start_at, output int ran);
        ran = 0;
        for (int i = 1; i <= 200; i++) begin
            cpu_pc = (i <= inc) ? base + 32'(4 * (i - 1)) : hold;
            start  = (i == start_at);
            tick();
            ran = i;
            if (done) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int ran;
        int seen;
        logic [2:0] exp_st [4];
        logic       exp_cr [4];
        exp_st = '{3'd2, 3'd2, 3'd2, 3'd3};
        exp_cr = '{1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1; reset_b = 1'b1; start = 1'b0; start_b = 1'b0;
        cpu_pc = '0; cpu_pc_b = '0;
        tick(); tick();
        reset = 1'b0; reset_b = 1'b0;

        check("rst_state", 32'(state), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_flags", {29'd0, done, halted, timeout}, 32'd0);

        // No-load variant: IDLE -> HOLD x3 -> RUN, never writing imem.
        check("b_idle", 32'(state_b), 32'd0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b_state%0d", k), 32'(state_b), 32'(exp_st[k]));
            check($sformatf("b_cpu_reset%0d", k), 32'(cpu_reset_b), 32'(exp_cr[k]));
            if (bus_b.imem_we) seen++;
            if (k < 3) tick();
        end
        check("b_no_imem_we", 32'(seen), 32'd0);

        // Full boot then halt: 10 incrementing PCs, then 0x40 held.
        tick();
        pulse_start();
        load_and_release("boot1");
        run_pc(10, 32'h18, 32'h40, 0, ran);
        check("halt_done", 32'(done), 32'd1);
        check("halt_state", 32'(state), 32'd4);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_no_timeout", 32'(timeout), 32'd0);
        check("halt_count", cycle_count, 32'd15);
        check("halt_run_cycles", 32'(ran), 32'd15);
        check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
        cpu_pc = 32'h1234;
        tick(); tick(); tick();
        check("halt_sticky_state", 32'(state), 32'd4);
        check("halt_frozen_count", cycle_count, 32'd15);

        // Restart from HALTED; start pulsed mid-RUN must be ignored; PC never stable.
        pulse_start();
        check("restart_state", 32'(state), 32'd1);
        check("restart_flags", {29'd0, done, halted, timeout}, 32'd0);
        check("restart_count", cycle_count, 32'd0);
        load_and_release("boot2");
        run_pc(1000, 32'h0, 32'h0, 5, ran);
        check("to_done", 32'(done), 32'd1);
        check("to_state", 32'(state), 32'd5);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_not_halted", 32'(halted), 32'd0);
        check("to_count", cycle_count, 32'd50);
        check("to_cpu_reset", 32'(cpu_reset), 32'd1);

        // Stable count reaches 4 on RUN cycle 50, the same cycle the budget expires.
        pulse_start();
        check("restart2_flags", {29'd0, done, halted, timeout}, 32'd0);
        load_and_release("boot3");
        run_pc(45, 32'h100, 32'h1000, 0, ran);
        check("both_state", 32'(state), 32'd4);
        check("both_halted", 32'(halted), 32'd1);
        check("both_no_timeout", 32'(timeout), 32'd0);
        check("both_count", cycle_count, 32'd50);

        // Reset while LOAD is on word 20.
        pulse_start();
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            if (bus.rom_addr == 10'd20) seen = 1;
            else tick();
        end
        check("mid_reached_w20", 32'(seen), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_state", 32'(state), 32'd0);
        check("mid_imem_we", 32'(bus.imem_we), 32'd0);
        check("mid_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("mid_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("mid_imem_wdata", bus.imem_wdata, 32'd0);
        check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_count_flags", cycle_count | {29'd0, done, halted, timeout}, 32'd0);
        tick(); tick();
        check("mid_stays_idle", {28'd0, bus.imem_we, state}, 32'd0);
        pulse_start();
        load_and_release("reload");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
